sram_arb: RTL and testbench
===========================

SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter AW, default 10: SRAM word-address width.
REQ-002 Parameter DW, default 32: SRAM data width.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_vld  input  2  per-requester access request; bit i = requester i.
REQ-006 req_rdy  output  2  per-requester accept; transfer when req_vld[i] & req_rdy[i].
REQ-007 req_wen  input  2  per-requester write enable (1 = write, 0 = read).
REQ-008 req_addr  input  2xAW  per-requester word address.
REQ-009 req_wdata  input  2xDW  per-requester write data.
REQ-010 rsp_vld  output  2  per-requester read-data valid, one-cycle pulse.
REQ-011 rsp_rdata  output  DW  read data, shared by both requesters, qualified by rsp_vld.
REQ-012 sram_rw  sram_if_t.master  -  single-port SRAM port (wen, addr, wdata out; rdata in).

Function
REQ-013 At most one bit of req_rdy SHALL be 1 in any cycle; req_rdy[i] is combinational from req_vld and the arbiter pointer.
REQ-014 The granted requester's wen/addr/wdata SHALL drive sram_rw combinationally in the grant cycle.
REQ-015 With no grant, the block drives sram_rw.wen=0; sram_rw.addr and sram_rw.wdata SHALL hold their last granted values.
REQ-016 An accepted read in cycle N SHALL assert rsp_vld[i] in cycle N+1 only, with rsp_rdata = sram_rw.rdata (1-cycle latency).
REQ-017 An accepted write SHALL produce no response and complete in its grant cycle.
REQ-018 Reads back-to-back from one requester SHALL sustain one per cycle; responses return in acceptance order.
REQ-019 rsp_vld has no backpressure; requesters SHALL always consume responses.
REQ-020 A requester SHALL hold req_wen/addr/wdata stable while req_vld=1 and req_rdy=0.
REQ-021 Read-after-write to the same address in consecutive cycles SHALL return the new data.
REQ-022 Pending-response state: rd_pend (1 bit) and rd_owner (1 bit), set on accepted read, else cleared next cycle.

Reset
REQ-023 During rst: req_rdy=0, rsp_vld=0, sram_rw.wen=0, sram_rw.addr=0, sram_rw.wdata=0, arbiter pointer=0, rd_pend=0.
REQ-024 rst asserted with a read in flight SHALL drop its response; no rsp_vld after rst deasserts.
REQ-025 First cycle after rst deassertion SHALL accept requests normally.

Configuration
REQ-026 Macro SRAM_ARB_RR_EN defined: round-robin; pointer moves to the other requester after each grant; a requester continuously requesting waits at most 1 cycle.
REQ-027 SRAM_ARB_RR_EN undefined: fixed priority, requester 0 always wins; pointer logic removed; requester 1 may starve.

Structure
REQ-028 Shared package sram_pkg SHALL hold the sram request struct typedef (wen, addr, wdata), the requester-count constant (2), and the requester-index typedef.
REQ-029 One sub-module, sram_arb_pick (2-way priority pick with rotating pointer), SHALL be instantiated; all other logic inline.

Verification
REQ-030 Write 0xDEADBEEF to addr 0x010 via req0, then read 0x010 via req1 -> rsp_vld=2'b10 one cycle after read accept, rsp_rdata=0xDEADBEEF.
REQ-031 Both requesters continuously read (req0 addr 0x001, req1 addr 0x002), RR enabled -> grants alternate 0,1,0,1; rsp_vld alternates with matching data.
REQ-032 Same as REQ-031 with SRAM_ARB_RR_EN undefined -> req_rdy=2'b01 every cycle; req1 never granted.
REQ-033 req0 write 0x5 to 0x020 in cycle N, read 0x020 in N+1 -> rsp_rdata=0x5 in N+2.
REQ-034 rst asserted the cycle after a read is accepted -> rsp_vld stays 0 through and after reset; req_rdy=0 while rst=1.
REQ-035 No requests for 10 cycles after a write -> sram_rw.wen=0 throughout, addr/wdata unchanged, rsp_vld=0.

Source files
------------

// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the two-requester SRAM arbiter.
//   SRAM_AW / SRAM_DW : default SRAM word-address and data widths
//   NREQ              : number of requesters sharing the SRAM port (2)
//   req_idx_t         : index of one requester
//   sram_req_t        : one SRAM access (wen, addr, wdata)
//   idx_onehot()      : requester index -> one-hot requester vector
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int SRAM_AW = 10;
    localparam int SRAM_DW = 32;
    localparam int NREQ    = 2;

    typedef logic req_idx_t;

    typedef struct packed {
        logic               wen;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] wdata;
    } sram_req_t;

    function automatic logic [NREQ-1:0] idx_onehot(input req_idx_t idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sram_if_t.sv
// ---------------------------------------------------------------------------
// sram_if_t
// Single-port synchronous SRAM connection.
//   wen   : 1 = write wdata to addr this cycle, 0 = read addr
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read address is presented
// modport master : arbiter side (drives wen/addr/wdata, receives rdata)
// modport slave  : memory side
// ---------------------------------------------------------------------------
interface sram_if_t #(
    parameter int AW = sram_pkg::SRAM_AW,
    parameter int DW = sram_pkg::SRAM_DW
);
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output wen, output addr, output wdata, input rdata);
    modport slave  (input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/sram_arb_pick.sv
// ---------------------------------------------------------------------------
// sram_arb_pick
// Two-way priority pick. The requester named by i_ptr has priority; if it is
// not requesting, the other requester wins. Purely combinational.
//   i_req : per-requester request vector
//   i_ptr : index of the requester with priority this cycle
//   o_gnt : one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module sram_arb_pick
    import sram_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  req_idx_t        i_ptr,
    output logic [NREQ-1:0] o_gnt
);

    req_idx_t w_other;

    assign w_other = ~i_ptr;

    always_comb begin
        o_gnt = '0;
        if (i_req[i_ptr]) begin
            o_gnt = idx_onehot(i_ptr);
        end else if (i_req[w_other]) begin
            o_gnt = idx_onehot(w_other);
        end
    end

endmodule

// File: rtl/sram_arb.sv
// ---------------------------------------------------------------------------
// sram_arb
// Arbitrates two requesters onto one single-port SRAM.
//
// Configuration macro: SRAM_ARB_RR_EN
//   defined   : round-robin, priority flips to the other requester after
//               every grant (a continuously requesting requester waits at
//               most one cycle)
//   undefined : fixed priority, requester 0 always wins, requester 1 may
//               starve; no pointer register exists
//
// Ports
//   clk        : clock, all state on posedge
//   rst        : asynchronous active-high reset
//   req_vld    : per-requester access request
//   req_rdy    : per-requester accept (at most one bit set)
//   req_wen    : per-requester write enable (1 = write, 0 = read)
//   req_addr   : per-requester word address
//   req_wdata  : per-requester write data
//   rsp_vld    : per-requester read-data valid, one-cycle pulse
//   rsp_rdata  : shared read data, qualified by rsp_vld
//   sram_rw    : SRAM master port
//
// Handshake: a request transfers in the cycle where req_vld[i] & req_rdy[i].
// req_rdy is combinational from req_vld and the priority pointer, so a
// requester must hold wen/addr/wdata stable while req_vld=1 and req_rdy=0.
// A transferred read returns data on rsp_vld[i] exactly one cycle later; a
// transferred write completes in its grant cycle with no response. rsp_vld
// has no backpressure.
//
// AW/DW must match the widths of the sram_rw interface instance and of
// sram_pkg (the request struct is sized by the package).
// ---------------------------------------------------------------------------
module sram_arb
    import sram_pkg::*;
#(
    parameter int AW = SRAM_AW,
    parameter int DW = SRAM_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_vld,
    output logic [NREQ-1:0]          req_rdy,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    input  logic [NREQ-1:0][DW-1:0]  req_wdata,
    output logic [NREQ-1:0]          rsp_vld,
    output logic [DW-1:0]            rsp_rdata,
    sram_if_t.master                 sram_rw
);

    // ---------------------------------------------------------------
    // Priority pointer
    // ---------------------------------------------------------------
    req_idx_t        w_ptr;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_rdy;
    logic            w_acc;
    req_idx_t        w_gidx;
    sram_req_t       w_sel;

`ifdef SRAM_ARB_RR_EN
    req_idx_t r_ptr;

    // After any grant the other requester gets priority next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_acc) begin
            r_ptr <= ~w_gidx;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    sram_arb_pick u_pick (
        .i_req (req_vld),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt)
    );

    // Nothing may be accepted while reset is held: the reset is
    // asynchronous, so the combinational ready path is gated directly.
    assign w_rdy   = rst ? '0 : w_gnt;
    assign req_rdy = w_rdy;
    assign w_acc   = |w_rdy;
    assign w_gidx  = w_rdy[1];

    // Granted requester's access, selected combinationally.
    always_comb begin
        w_sel       = '0;
        w_sel.wen   = req_wen[w_gidx];
        w_sel.addr  = req_addr[w_gidx];
        w_sel.wdata = req_wdata[w_gidx];
    end

    // ---------------------------------------------------------------
    // SRAM port: live request when granted, otherwise a harmless read
    // of the last granted address (addr/wdata are held, wen forced low).
    // ---------------------------------------------------------------
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_acc) begin
            r_addr  <= w_sel.addr;
            r_wdata <= w_sel.wdata;
        end
    end

    assign sram_rw.wen   = w_acc & w_sel.wen;
    assign sram_rw.addr  = w_acc ? w_sel.addr  : r_addr;
    assign sram_rw.wdata = w_acc ? w_sel.wdata : r_wdata;

    // ---------------------------------------------------------------
    // Read response tracking. Only one access reaches the SRAM per
    // cycle and latency is fixed at one, so a single pending flag plus
    // owner is enough and responses stay in acceptance order.
    // Reset clears r_rd_pend immediately, dropping any in-flight read.
    // ---------------------------------------------------------------
    logic     r_rd_pend;
    req_idx_t r_rd_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_pend  <= w_acc & ~w_sel.wen;
            r_rd_owner <= w_gidx;
        end
    end

    assign rsp_vld   = r_rd_pend ? idx_onehot(r_rd_owner) : '0;
    assign rsp_rdata = sram_rw.rdata;

endmodule

// File: tb/tb_sram_arb.sv
// ---------------------------------------------------------------------------
// tb_sram_arb
// Directed bench for sram_arb with a behavioural one-cycle-latency SRAM.
// Inputs are driven 1 time unit after posedge; outputs are sampled on the
// following negedge (combinational grant-cycle values) or on the negedge of
// the next cycle (read responses).
// ---------------------------------------------------------------------------
module tb_sram_arb;

    localparam int AW = 10;
    localparam int DW = 32;

    // -------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // -------------------------------------------------------------------
    // DUT and SRAM model
    // -------------------------------------------------------------------
    logic [1:0]         req_vld;
    logic [1:0]         req_rdy;
    logic [1:0]         req_wen;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata;
    logic [1:0]         rsp_vld;
    logic [DW-1:0]      rsp_rdata;

    sram_if_t #(.AW(AW), .DW(DW)) sram_rw ();

    sram_arb #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_vld   (rsp_vld),
        .rsp_rdata (rsp_rdata),
        .sram_rw   (sram_rw)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (sram_rw.wen) begin
            mem[sram_rw.addr] <= sram_rw.wdata;
        end else begin
            sram_rw.rdata <= mem[sram_rw.addr];
        end
    end

    // -------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    // -------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------
    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_vld[i]   = v;
        req_wen[i]   = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------
    task automatic test_reset();
        set_req(0, 1'b1, 1'b1, 10'h155, 32'h1234_5678);
        set_req(1, 1'b1, 1'b0, 10'h0AA, 32'h8765_4321);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 2'b00) begin
            n_fail++; $display("FAIL reset_rdy got=%b exp=00", req_rdy);
        end
        n_checks++;
        if (sram_rw.wen !== 1'b0) begin
            n_fail++; $display("FAIL reset_wen got=%b exp=0", sram_rw.wen);
        end
        n_checks++;
        if (sram_rw.addr !== 10'h000) begin
            n_fail++; $display("FAIL reset_addr got=%h exp=000", sram_rw.addr);
        end
        n_checks++;
        if (sram_rw.wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_wdata got=%h exp=0", sram_rw.wdata);
        end
        n_checks++;
        if (rsp_vld !== 2'b00) begin
            n_fail++; $display("FAIL reset_rsp_vld got=%b exp=00", rsp_vld);
        end
    endtask

    // Write via req0 in the first cycle after reset, read back via req1.
    task automatic test_write_read();
        next_cycle();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF);
        set_req(1, 1'b0, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 2'b01) begin
            n_fail++; $display("FAIL wr_rdy got=%b exp=01", req_rdy);
        end
        n_checks++;
        if (sram_rw.wen !== 1'b1 || sram_rw.addr !== 10'h010 || sram_rw.wdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_port got=%b/%h/%h exp=1/010/deadbeef",
                               sram_rw.wen, sram_rw.addr, sram_rw.wdata);
        end
        next_cycle();
        set_req(0, 1'b0, 1'b0, 10'h000, 32'h0);
        set_req(1, 1'b1, 1'b0, 10'h010, 32'h0);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 2'b10 || sram_rw.wen !== 1'b0 || sram_rw.addr !== 10'h010) begin
            n_fail++; $display("FAIL rd_accept got=%b/%b/%h exp=10/0/010",
                               req_rdy, sram_rw.wen, sram_rw.addr);
        end
        n_checks++;
        if (rsp_vld !== 2'b00) begin
            n_fail++; $display("FAIL wr_no_rsp got=%b exp=00", rsp_vld);
        end
        next_cycle();
        set_req(1, 1'b0, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 2'b10 || rsp_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_rsp got=%b/%h exp=10/deadbeef", rsp_vld, rsp_rdata);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 2'b00) begin
            n_fail++; $display("FAIL rd_rsp_pulse got=%b exp=00", rsp_vld);
        end
    endtask

    // Write then read the same address in consecutive cycles.
    task automatic test_raw();
        next_cycle();
        set_req(0, 1'b1, 1'b1, 10'h020, 32'h0000_0005);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 10'h020, 32'h0);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 2'b01) begin
            n_fail++; $display("FAIL raw_rd_rdy got=%b exp=01", req_rdy);
        end
        next_cycle();
        set_req(0, 1'b0, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 2'b01 || rsp_rdata !== 32'h0000_0005) begin
            n_fail++; $display("FAIL raw_rsp got=%b/%h exp=01/00000005", rsp_vld, rsp_rdata);
        end
    endtask

    // Both requesters read continuously; grant pattern depends on the build.
    task automatic test_contention();
        logic [1:0]    exp_gnt;
        logic [1:0]    prev_gnt;
        logic [DW-1:0] exp_d;
        next_cycle();
        set_req(0, 1'b1, 1'b1, 10'h001, 32'h1111_1111);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 10'h000, 32'h0);
        set_req(1, 1'b1, 1'b1, 10'h002, 32'h2222_2222);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 2'b10) begin
            n_fail++; $display("FAIL pre_wr1_rdy got=%b exp=10", req_rdy);
        end
        prev_gnt = 2'b00;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            set_req(0, 1'b1, 1'b0, 10'h001, 32'h0);
            set_req(1, 1'b1, 1'b0, 10'h002, 32'h0);
`ifdef SRAM_ARB_RR_EN
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_gnt = 2'b01;
`endif
            @(negedge clk);
            n_checks++;
            if (req_rdy !== exp_gnt) begin
                n_fail++; $display("FAIL cont_rdy k=%0d got=%b exp=%b", k, req_rdy, exp_gnt);
            end
            if (k > 0) begin
                exp_d = exp_q.pop_front();
                n_checks++;
                if (rsp_vld !== prev_gnt || rsp_rdata !== exp_d) begin
                    n_fail++; $display("FAIL cont_rsp k=%0d got=%b/%h exp=%b/%h",
                                       k, rsp_vld, rsp_rdata, prev_gnt, exp_d);
                end
            end
            exp_q.push_back(exp_gnt[0] ? 32'h1111_1111 : 32'h2222_2222);
            prev_gnt = exp_gnt;
        end
        next_cycle();
        set_req(0, 1'b0, 1'b0, 10'h000, 32'h0);
        set_req(1, 1'b0, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        exp_d = exp_q.pop_front();
        n_checks++;
        if (rsp_vld !== prev_gnt || rsp_rdata !== exp_d) begin
            n_fail++; $display("FAIL cont_last_rsp got=%b/%h exp=%b/%h",
                               rsp_vld, rsp_rdata, prev_gnt, exp_d);
        end
    endtask

    // One requester alone issues reads every cycle.
    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] datas [3];
        logic [DW-1:0] exp_d;
        addrs[0] = 10'h002; addrs[1] = 10'h001; addrs[2] = 10'h002;
        datas[0] = 32'h2222_2222; datas[1] = 32'h1111_1111; datas[2] = 32'h2222_2222;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            if (k < 3) set_req(1, 1'b1, 1'b0, addrs[k], 32'h0);
            else       set_req(1, 1'b0, 1'b0, 10'h000, 32'h0);
            @(negedge clk);
            if (k < 3) begin
                n_checks++;
                if (req_rdy !== 2'b10) begin
                    n_fail++; $display("FAIL b2b_rdy k=%0d got=%b exp=10", k, req_rdy);
                end
            end
            if (k > 0) begin
                exp_d = exp_q.pop_front();
                n_checks++;
                if (rsp_vld !== 2'b10 || rsp_rdata !== exp_d) begin
                    n_fail++; $display("FAIL b2b_rsp k=%0d got=%b/%h exp=10/%h",
                                       k, rsp_vld, rsp_rdata, exp_d);
                end
            end
            if (k < 3) exp_q.push_back(datas[k]);
        end
    endtask

    // Reset lands the cycle after a read is accepted.
    task automatic test_reset_inflight();
        next_cycle();
        set_req(0, 1'b1, 1'b0, 10'h001, 32'h0);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 2'b01) begin
            n_fail++; $display("FAIL rstf_accept got=%b exp=01", req_rdy);
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            rst = 1'b1;
            @(negedge clk);
            n_checks++;
            if (rsp_vld !== 2'b00 || req_rdy !== 2'b00) begin
                n_fail++; $display("FAIL rstf_during k=%0d got=%b/%b exp=00/00", k, rsp_vld, req_rdy);
            end
        end
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            rst = 1'b0;
            set_req(0, 1'b0, 1'b0, 10'h000, 32'h0);
            @(negedge clk);
            n_checks++;
            if (rsp_vld !== 2'b00) begin
                n_fail++; $display("FAIL rstf_after k=%0d got=%b exp=00", k, rsp_vld);
            end
        end
        next_cycle();
        set_req(0, 1'b1, 1'b0, 10'h001, 32'h0);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 2'b01) begin
            n_fail++; $display("FAIL rstf_reaccept got=%b exp=01", req_rdy);
        end
        next_cycle();
        set_req(0, 1'b0, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 2'b01 || rsp_rdata !== 32'h1111_1111) begin
            n_fail++; $display("FAIL rstf_rsp got=%b/%h exp=01/11111111", rsp_vld, rsp_rdata);
        end
    endtask

    // Idle after a write: port holds last granted addr/wdata with wen low.
    task automatic test_idle_hold();
        next_cycle();
        set_req(1, 1'b1, 1'b1, 10'h3FF, 32'hCAFE_F00D);
        @(negedge clk);
        n_checks++;
        if (req_rdy !== 2'b10 || sram_rw.wen !== 1'b1) begin
            n_fail++; $display("FAIL idle_wr got=%b/%b exp=10/1", req_rdy, sram_rw.wen);
        end
        next_cycle();
        set_req(1, 1'b0, 1'b0, 10'h000, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (sram_rw.wen !== 1'b0 || sram_rw.addr !== 10'h3FF ||
                sram_rw.wdata !== 32'hCAFE_F00D || rsp_vld !== 2'b00) begin
                n_fail++; $display("FAIL idle_hold k=%0d got=%b/%h/%h/%b exp=0/3ff/cafef00d/00",
                                   k, sram_rw.wen, sram_rw.addr, sram_rw.wdata, rsp_vld);
            end
            next_cycle();
        end
    endtask

    // -------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------
    initial begin
        req_vld   = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        test_write_read();
        test_raw();
        test_contention();
        test_back_to_back();
        test_reset_inflight();
        test_idle_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
